// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle MIPS control FSM (master) and its datapath (slave).
`timescale 1ns/1ps
interface mc_ctrl_if;
    logic [5:0]  op_i;
    logic [5:0]  func_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        iord_o;
    logic        ir_we_o;
    logic        pc_we_o;
    logic        pc_src_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  alu_ctl_o;
    logic        reg_we_o;
    logic        reg_dst_o;
    logic        mem_to_reg_o;
    logic        instr_done_o;
    logic        illegal_o;
    logic [2:0]  state_o;
    logic [31:0] cycle_cnt_o;
    logic [31:0] instr_cnt_o;

    modport master (
        input  op_i, func_i, rt_i, rd_i, zero_i, mem_ready_i,
        output mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, alu_ctl_o, reg_we_o, reg_dst_o,
               mem_to_reg_o, instr_done_o, illegal_o, state_o,
               cycle_cnt_o, instr_cnt_o
    );

    modport slave (
        output op_i, func_i, rt_i, rd_i, zero_i, mem_ready_i,
        input  mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, alu_ctl_o, reg_we_o, reg_dst_o,
               mem_to_reg_o, instr_done_o, illegal_o, state_o,
               cycle_cnt_o, instr_cnt_o
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for a 10-instruction MIPS subset sharing one memory port.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam int unsigned TW  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [31:0] TMO = 32'(MEM_TIMEOUT);

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic       is_r, is_addi, is_lw, is_sw, is_slti, is_beq, func_ok, op_ok;
    logic [2:0] r_alu;
    logic [4:0] dest_idx;

    logic       mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c, pc_src_c;
    logic       alu_src_a_c, reg_we_c, reg_dst_c, mem_to_reg_c, instr_done_c;
    logic       illegal_c, wait_c, tmo_hit_c;
    logic [1:0] alu_src_b_c;
    logic [2:0] alu_ctl_c;

    always_comb begin
        is_r    = (bus.op_i == 6'h00);
        is_addi = (bus.op_i == 6'h08);
        is_lw   = (bus.op_i == 6'h23);
        is_sw   = (bus.op_i == 6'h2b);
        is_slti = (bus.op_i == 6'h0a);
        is_beq  = (bus.op_i == 6'h04);
        func_ok = 1'b1;
        r_alu   = 3'd0;
        case (bus.func_i)
            6'h20:   r_alu = 3'd0;
            6'h22:   r_alu = 3'd1;
            6'h24:   r_alu = 3'd2;
            6'h25:   r_alu = 3'd3;
            6'h2a:   r_alu = 3'd4;
            default: func_ok = 1'b0;
        endcase
        op_ok    = (is_r && func_ok) || is_addi || is_lw || is_sw || is_slti || is_beq;
        dest_idx = is_r ? bus.rd_i : bus.rt_i;
    end

    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        iord_c       = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'd0;
        alu_ctl_c    = 3'd0;
        reg_we_c     = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'd1;
                if (bus.mem_ready_i) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target while the opcode is decoded.
                alu_src_b_c = 2'd3;
                state_d     = op_ok ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                if (is_r) begin
                    alu_ctl_c = r_alu;
                    state_d   = S_WB;
                end else if (is_addi || is_lw || is_sw) begin
                    alu_src_b_c = 2'd2;
                    state_d     = is_addi ? S_WB : S_MEM;
                end else if (is_slti) begin
                    alu_src_b_c = 2'd2;
                    alu_ctl_c   = 3'd4;
                    state_d     = S_WB;
                end else if (is_beq) begin
                    alu_ctl_c    = 3'd1;
                    pc_src_c     = 1'b1;
                    pc_we_c      = bus.zero_i;
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                mem_we_c  = is_sw;
                if (!(is_lw || is_sw)) begin
                    state_d = S_TRAP;
                end else if (bus.mem_ready_i) begin
                    instr_done_c = is_sw;
                    state_d      = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_we_c     = (dest_idx != 5'd0);
                reg_dst_c    = is_r;
                mem_to_reg_c = is_lw;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase

        // A stalled memory handshake that exhausts its budget overrides the normal transition.
        wait_c    = mem_req_c && !bus.mem_ready_i;
        tmo_hit_c = (TMO != 32'd0) && wait_c && ((32'(tmo_q) + 32'd1) == TMO);
        if (tmo_hit_c) begin
            state_d = S_TRAP;
        end
        tmo_d = (wait_c && (state_d == state_q)) ? (tmo_q + TW'(1)) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Controls are forced low while reset is held so no write can escape mid-reset.
    assign bus.mem_req_o    = rst_i & mem_req_c;
    assign bus.mem_we_o     = rst_i & mem_we_c;
    assign bus.iord_o       = rst_i & iord_c;
    assign bus.ir_we_o      = rst_i & ir_we_c;
    assign bus.pc_we_o      = rst_i & pc_we_c;
    assign bus.pc_src_o     = rst_i & pc_src_c;
    assign bus.alu_src_a_o  = rst_i & alu_src_a_c;
    assign bus.alu_src_b_o  = {2{rst_i}} & alu_src_b_c;
    assign bus.alu_ctl_o    = {3{rst_i}} & alu_ctl_c;
    assign bus.reg_we_o     = rst_i & reg_we_c;
    assign bus.reg_dst_o    = rst_i & reg_dst_c;
    assign bus.mem_to_reg_o = rst_i & mem_to_reg_c;
    assign bus.instr_done_o = rst_i & instr_done_c;
    assign bus.illegal_o    = rst_i & illegal_c;
    assign bus.state_o      = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = (state_q != S_TRAP) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        instr_cnt_d = instr_done_c ? instr_cnt_q + 32'd1 : instr_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign bus.cycle_cnt_o = cycle_cnt_q;
    assign bus.instr_cnt_o = instr_cnt_q;
`else
    assign bus.cycle_cnt_o = 32'd0;
    assign bus.instr_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed plus randomized check of mc_ctrl_fsm against a per-instruction state-trace model.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;
    localparam int TMO = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    mc_ctrl_if ifc ();

    mc_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;
    int exp_cyc = 0;
    int exp_ins = 0;
    int trace[$];

    // Instruction table: opcode, function field, ALU operation used in EXEC.
    logic [5:0] k_op   [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2b, 6'h0a, 6'h04};
    logic [5:0] k_func [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [2:0] k_alu  [10] = '{3'd0,  3'd1,  3'd2,  3'd3,  3'd4,  3'd0,  3'd0,  3'd0,  3'd4,  3'd1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op, input logic [5:0] func);
        if (op == 6'h00)
            return (func == 6'h20) || (func == 6'h22) || (func == 6'h24) ||
                   (func == 6'h25) || (func == 6'h2a);
        return (op == 6'h08) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h0a) || (op == 6'h04);
    endfunction

    // Expected state sequence for one instruction; a trace that ends in TRAP (5) stops there.
    function automatic void build_trace(input logic [5:0] op, input logic [5:0] func,
                                        input int fw, input int mw);
        trace.delete();
        for (int i = 0; i <= fw && i < TMO; i++) trace.push_back(0);
        if (fw >= TMO) begin trace.push_back(5); return; end
        trace.push_back(1);
        if (!legal(op, func)) begin trace.push_back(5); return; end
        trace.push_back(2);
        if (op == 6'h04) return;
        if (op == 6'h23 || op == 6'h2b) begin
            for (int i = 0; i <= mw && i < TMO; i++) trace.push_back(3);
            if (mw >= TMO) begin trace.push_back(5); return; end
            if (op == 6'h2b) return;
        end
        trace.push_back(4);
    endfunction

    task automatic do_reset();
        rst_i = 1'b0;
        ifc.mem_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_state", 32'(ifc.state_o), 32'd0);
        chk("rst_mem_req", 32'(ifc.mem_req_o), 32'd0);
        chk("rst_illegal", 32'(ifc.illegal_o), 32'd0);
        chk("rst_done", 32'(ifc.instr_done_o), 32'd0);
        chk("rst_cycle_cnt", ifc.cycle_cnt_o, 32'd0);
        chk("rst_instr_cnt", ifc.instr_cnt_o, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        exp_cyc = 0;
        exp_ins = 0;
    endtask

    // Called at posedge+1; returns the number of non-trap cycles taken.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input logic [2:0] alu,
                             input logic [4:0] rt, input logic [4:0] rd, input logic zero,
                             input int fw, input int mw, output int lat);
        int fidx = 0;
        int midx = 0;
        bit is_r, is_lw, is_sw, is_beq, rdy;
        is_r   = (op == 6'h00);
        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2b);
        is_beq = (op == 6'h04);
        lat = 0;
        ifc.op_i = op; ifc.func_i = func; ifc.rt_i = rt; ifc.rd_i = rd; ifc.zero_i = zero;
        build_trace(op, func, fw, mw);
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i] == 5) begin
                for (int t = 0; t < 20; t++) begin
                    ifc.mem_ready_i = 1'($urandom_range(1));
                    @(negedge clk_i);
                    chk("trap_state", 32'(ifc.state_o), 32'd5);
                    chk("trap_illegal", 32'(ifc.illegal_o), 32'd1);
                    chk("trap_mem_req", 32'(ifc.mem_req_o), 32'd0);
                    chk("trap_writes", {29'd0, ifc.reg_we_o, ifc.pc_we_o, ifc.ir_we_o}, 32'd0);
                    @(posedge clk_i); #1;
                end
                return;
            end
            if (trace[i] == 0)      begin rdy = (fidx == fw); fidx++; end
            else if (trace[i] == 3) begin rdy = (midx == mw); midx++; end
            else                    rdy = 1'($urandom_range(1));
            ifc.mem_ready_i = rdy;
            @(negedge clk_i);
            chk("state", 32'(ifc.state_o), 32'(trace[i]));
            chk("instr_done", 32'(ifc.instr_done_o), 32'(i == trace.size() - 1));
            case (trace[i])
                0: begin
                    chk("fetch_req", {28'd0, ifc.mem_req_o, ifc.iord_o, ifc.alu_src_a_o, ifc.pc_src_o}, 32'h8);
                    chk("fetch_alu", {27'd0, ifc.alu_src_b_o, ifc.alu_ctl_o}, {27'd0, 2'd1, 3'd0});
                    chk("fetch_we", {30'd0, ifc.ir_we_o, ifc.pc_we_o}, {30'd0, rdy, rdy});
                    chk("fetch_reg_we", 32'(ifc.reg_we_o), 32'd0);
                end
                1: begin
                    chk("dec_alu", {26'd0, ifc.alu_src_a_o, ifc.alu_src_b_o, ifc.alu_ctl_o}, {26'd0, 1'b0, 2'd3, 3'd0});
                    chk("dec_ctl", {29'd0, ifc.mem_req_o, ifc.pc_we_o, ifc.reg_we_o}, 32'd0);
                end
                2: begin
                    chk("exec_alu", {26'd0, ifc.alu_src_a_o, ifc.alu_src_b_o, ifc.alu_ctl_o},
                        {26'd0, 1'b1, ((is_r || is_beq) ? 2'd0 : 2'd2), alu});
                    chk("exec_pc", {30'd0, ifc.pc_src_o, ifc.pc_we_o}, {30'd0, is_beq, is_beq & zero});
                    chk("exec_ctl", {30'd0, ifc.mem_req_o, ifc.reg_we_o}, 32'd0);
                end
                3: begin
                    chk("mem_ctl", {29'd0, ifc.mem_req_o, ifc.iord_o, ifc.mem_we_o}, {29'd0, 1'b1, 1'b1, is_sw});
                    chk("mem_reg_we", 32'(ifc.reg_we_o), 32'd0);
                end
                4: begin
                    chk("wb_reg_we", 32'(ifc.reg_we_o), 32'(((is_r ? rd : rt) != 5'd0)));
                    chk("wb_sel", {30'd0, ifc.reg_dst_o, ifc.mem_to_reg_o}, {30'd0, is_r, is_lw});
                    chk("wb_mem_req", 32'(ifc.mem_req_o), 32'd0);
                end
                default: ;
            endcase
            exp_cyc++;
            if (i == trace.size() - 1) exp_ins++;
            lat++;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic chk_counters(input string tag, input int cyc, input int ins);
`ifdef MC_PERF_CNT_EN
        chk({tag, "_cycle_cnt"}, ifc.cycle_cnt_o, 32'(cyc));
        chk({tag, "_instr_cnt"}, ifc.instr_cnt_o, 32'(ins));
`else
        chk({tag, "_cycle_cnt"}, ifc.cycle_cnt_o, 32'd0);
        chk({tag, "_instr_cnt"}, ifc.instr_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        int lat;
        int k, fw, mw;
        ifc.op_i = '0; ifc.func_i = '0; ifc.rt_i = '0; ifc.rd_i = '0;
        ifc.zero_i = 1'b0; ifc.mem_ready_i = 1'b0;
        #2;
        do_reset();

        run_instr(6'h00, 6'h20, 3'd0, 5'd1, 5'd3, 1'b0, 0, 0, lat);
        chk("lat_add", 32'(lat), 32'd4);
        run_instr(6'h23, 6'h00, 3'd0, 5'd7, 5'd0, 1'b0, 0, 2, lat);
        chk("lat_lw_wait2", 32'(lat), 32'd7);
        run_instr(6'h04, 6'h00, 3'd1, 5'd2, 5'd0, 1'b1, 0, 0, lat);
        chk("lat_beq_taken", 32'(lat), 32'd3);
        run_instr(6'h04, 6'h00, 3'd1, 5'd2, 5'd0, 1'b0, 0, 0, lat);
        chk("lat_beq_not_taken", 32'(lat), 32'd3);
        run_instr(6'h08, 6'h00, 3'd0, 5'd0, 5'd9, 1'b0, 0, 0, lat);
        chk("lat_addi_r0", 32'(lat), 32'd4);
        run_instr(6'h00, 6'h25, 3'd3, 5'd4, 5'd5, 1'b0, TMO - 1, 0, lat);
        chk("lat_fetch_wait15", 32'(lat), 32'(4 + TMO - 1));
        run_instr(6'h2b, 6'h00, 3'd0, 5'd4, 5'd0, 1'b0, 0, TMO - 1, lat);
        chk("lat_sw_wait15", 32'(lat), 32'(4 + TMO - 1));

        for (int n = 0; n < 40; n++) begin
            k  = $urandom_range(9);
            fw = $urandom_range(3);
            mw = $urandom_range(3);
            run_instr(k_op[k], k_func[k], k_alu[k], 5'($urandom_range(3)), 5'($urandom_range(3)),
                      1'($urandom_range(1)), fw, mw, lat);
        end
        chk_counters("random", exp_cyc, exp_ins);

        do_reset();
        for (int n = 0; n < 4; n++) run_instr(6'h00, 6'h20, 3'd0, 5'd1, 5'd3, 1'b0, 0, 0, lat);
        chk_counters("four_add", 16, 4);

        do_reset();
        run_instr(6'h3f, 6'h00, 3'd0, 5'd0, 5'd0, 1'b0, 0, 0, lat);
        do_reset();
        run_instr(6'h00, 6'h21, 3'd0, 5'd0, 5'd0, 1'b0, 0, 0, lat);
        do_reset();
        run_instr(6'h23, 6'h00, 3'd0, 5'd1, 5'd0, 1'b0, 0, TMO, lat);
        do_reset();
        run_instr(6'h00, 6'h20, 3'd0, 5'd1, 5'd3, 1'b0, TMO, 0, lat);
        chk("lat_fetch_timeout", 32'(lat), 32'(TMO));

        // Asynchronous reset in the middle of a clock phase while trapped.
        #2 rst_i = 1'b0;
        #1;
        chk("async_rst_state", 32'(ifc.state_o), 32'd0);
        chk("async_rst_illegal", 32'(ifc.illegal_o), 32'd0);
        chk("async_rst_mem_req", 32'(ifc.mem_req_o), 32'd0);
        do_reset();
        run_instr(6'h0a, 6'h00, 3'd4, 5'd6, 5'd0, 1'b0, 1, 0, lat);
        chk("lat_slti_after_rst", 32'(lat), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control FSM that sequences the shared MIPS datapath (PC, IR, register file, single ALU, unified memory port) for the ten-instruction subset: ADD, SUB, AND, OR, SLT, ADDI, LW, SW, SLTI, BEQ.
- Replaces single-cycle execution with FETCH/DECODE/EXEC/MEM/WB steps.
- Arbitrates the one memory port between instruction fetch and data access through a req/ready handshake.
- Traps on illegal encodings and on memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles mem_req_o may wait for mem_ready_i before the FSM traps. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- op_i  in  6  IR[31:26]
- func_i  in  6  IR[5:0]
- rt_i  in  5  IR[20:16]
- rd_i  in  5  IR[15:11]
- zero_i  in  1  ALU equality flag (A==B)
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write (SW)
- iord_o  out  1  address select: 0=PC, 1=ALUOut
- ir_we_o  out  1  load IR
- pc_we_o  out  1  load PC
- pc_src_o  out  1  0=ALU result (PC+4), 1=ALUOut (branch target)
- alu_src_a_o  out  1  0=PC, 1=A
- alu_src_b_o  out  2  0=B, 1=const 4, 2=sext(imm), 3=sext(imm)<<2
- alu_ctl_o  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT
- reg_we_o  out  1  register-file write
- reg_dst_o  out  1  0=rt, 1=rd
- mem_to_reg_o  out  1  0=ALUOut, 1=MDR
- instr_done_o  out  1  one-cycle pulse on instruction retire
- illegal_o  out  1  sticky trap flag
- state_o  out  3  current state
- cycle_cnt_o  out  32  see Optional Feature
- instr_cnt_o  out  32  see Optional Feature

Behaviour:
- Reset: rst_i is asynchronous, active-low; clock is clk_i. On reset:
  - state = FETCH (0);
  - all outputs 0, including illegal_o and the counters;
  - timeout counter cleared.
- Reset mid-operation aborts the instruction immediately; no pending writes.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Values 6 and 7 go to TRAP.
- Outputs not listed for a state are 0.
- FETCH:
  - mem_req_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_ctl_o=ADD.
  - When mem_ready_i=1 in the same cycle: ir_we_o=1, pc_we_o=1, pc_src_o=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - alu_src_a_o=0, alu_src_b_o=3, alu_ctl_o=ADD (branch target into ALUOut).
  - Next state: EXEC for a legal op/func; TRAP otherwise.
  - Legal ops: 0x00, 0x08, 0x23, 0x2b, 0x0a, 0x04.
  - Legal R-type func: 0x20, 0x22, 0x24, 0x25, 0x2a.
- EXEC:
  - R-type: alu_src_a_o=1, alu_src_b_o=0, alu_ctl_o from func; next state WB.
  - ADDI, LW, SW: alu_src_a_o=1, alu_src_b_o=2, ADD. ADDI goes to WB; LW and SW go to MEM.
  - SLTI: alu_src_a_o=1, alu_src_b_o=2, SLT; next state WB.
  - BEQ: alu_src_a_o=1, alu_src_b_o=0, SUB; pc_src_o=1; pc_we_o=zero_i (combinational); instr_done_o=1; next state FETCH.
- MEM:
  - mem_req_o=1, iord_o=1, mem_we_o=(op==SW).
  - Stay in MEM until mem_ready_i=1.
  - On ready: LW goes to WB; SW pulses instr_done_o and goes to FETCH.
- WB:
  - reg_we_o=1 unless the destination index is 0; destination is rd for R-type, rt otherwise. A write to r0 is suppressed, but the instruction still retires.
  - reg_dst_o=1 for R-type; mem_to_reg_o=1 for LW.
  - instr_done_o=1; next state FETCH.
- TRAP:
  - illegal_o=1, all other controls 0.
  - TRAP is absorbing; only reset exits it.
- Timeout:
  - The counter increments each cycle mem_req_o=1 and mem_ready_i=0, and clears on handshake or state change.
  - When the count reaches MEM_TIMEOUT (if non-zero), the next state is TRAP.
- Latencies with zero memory wait:
  - BEQ: 3 cycles.
  - R-type, ADDI, SLTI, SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- mem_ready_i is ignored when mem_req_o=0.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- When defined:
  - cycle_cnt_o increments every cycle not in TRAP.
  - instr_cnt_o increments on each instr_done_o.
  - Both are 32-bit, wrap at 0xFFFFFFFF→0, and clear on reset.
- When undefined: both ports are driven constant 0 and no counter flops are present.

Test Plan:
- ADD (op 0, func 0x20, rd=3) with mem_ready_i tied 1 → states 0,1,2,4,0; reg_we_o=1 and reg_dst_o=1 in WB; instr_done_o pulses at cycle 4.
- LW with mem_ready_i asserted 2 cycles late in MEM → MEM held 3 cycles, mem_we_o=0, iord_o=1; WB mem_to_reg_o=1; total 7 cycles.
- BEQ, once with zero_i=1 and once with zero_i=0 → EXEC pc_we_o=1/0 with pc_src_o=1; retire in 3 cycles.
- ADDI with rt=0 → WB reg_we_o=0 and instr_done_o=1. Then op 0x3f → TRAP, illegal_o=1 stays set for 20 cycles.
- FETCH with mem_ready_i=0 and MEM_TIMEOUT=16 → TRAP after 16 wait cycles. Then drop rst_i mid-TRAP → state 0, illegal_o=0 asynchronously.
- With MC_PERF_CNT_EN: run 4 ADDs → instr_cnt_o=4, cycle_cnt_o=16.
